// File: rtl/mc_seq.sv
// mc_seq: multi-cycle fetch/execute sequencer for the RV32 core.
//
// This block owns the program counter, the instruction register, the
// retired-instruction counter, and the sticky halt and bus-error flags.
// It fetches each instruction over a valid/ready instruction-memory
// handshake and latches it into inst. The external combinational decode
// and datapath read inst and return decode flags plus pc_next. Loads and
// stores use a second valid/ready handshake to data memory. Each
// instruction then retires through a single write-back cycle.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_req_valid    fetch request, imem_addr valid while high
//   imem_req_ready    instruction memory accepts the request
//   imem_addr         fetch address (always equals pc)
//   imem_rsp_valid    instruction data valid
//   imem_rsp_data     fetched instruction
//   inst              latched instruction driving decode
//   pc                current program counter
//   dec_is_load       decoded load
//   dec_is_store      decoded store
//   dec_is_ebreak     decoded ebreak
//   dec_reg_write     decoded register-file write
//   pc_next           next PC computed by the datapath
//   dmem_req_valid    data memory request
//   dmem_req_ready    data memory accepts the request
//   dmem_we           store request (qualified by dmem_req_valid)
//   dmem_rsp_valid    load data valid / store completion
//   dmem_rsp_data     load data
//   ld_data           latched load data for register-file writeback
//   rf_we             gated register-file write enable (write-back only)
//   retire            one-cycle pulse per retired instruction
//   instret           retired-instruction count
//   halted            sticky, set by ebreak
//   bus_err           sticky, set by handshake timeout or misaligned pc_next
module mc_seq #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              TIMEOUT  = 255,
    parameter int              CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  pc,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             dec_is_ebreak,
    input  logic             dec_reg_write,
    input  logic [XLEN-1:0]  pc_next,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic             dmem_we,
    input  logic             dmem_rsp_valid,
    input  logic [XLEN-1:0]  dmem_rsp_data,
    output logic [XLEN-1:0]  ld_data,
    output logic             rf_we,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             bus_err
);

    // The wait counter only has to reach TIMEOUT, so it is sized to hold that value.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        FETCH,
        WAIT_I,
        EXEC,
        MEM,
        WAIT_D,
        WB,
        HALT,
        ERR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_state;
    logic              exit_cond;
    logic              timed_out;
    logic              pc_misaligned;

    assign pc_misaligned = (pc_next[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            inst     <= 32'h0000_0013;
            ld_data  <= '0;
            instret  <= '0;
            halted   <= 1'b0;
            bus_err  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;

            // Any state change clears the counter. This covers entry into each
            // handshake state. While stalled in a handshake state it counts.
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (wait_state) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (state == WAIT_I && imem_rsp_valid) begin
                inst <= imem_rsp_data;
            end

            if (state == WAIT_D && dmem_rsp_valid && dec_is_load) begin
                ld_data <= dmem_rsp_data;
            end

            // A misaligned target still retires, but the PC keeps pointing
            // at the faulting instruction so it can be inspected.
            if (state == WB) begin
                instret <= instret + CNT_W'(1);
                if (!pc_misaligned) begin
                    pc <= pc_next;
                end
            end

            if (state_next == HALT) begin
                halted <= 1'b1;
            end

            if (state_next == ERR) begin
                bus_err <= 1'b1;
            end
        end
    end

    // Outputs are gated by rst so the reset cycle never shows a request,
    // write enable or retire pulse, whatever state the register held.
    always_comb begin
        state_next     = state;
        wait_state     = 1'b0;
        exit_cond      = 1'b0;
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_we        = 1'b0;
        rf_we          = 1'b0;
        retire         = 1'b0;

        case (state)
            FETCH: begin
                wait_state     = 1'b1;
                exit_cond      = imem_req_ready;
                imem_req_valid = !rst;
                if (imem_req_ready) begin
                    state_next = WAIT_I;
                end
            end
            WAIT_I: begin
                wait_state = 1'b1;
                exit_cond  = imem_rsp_valid;
                if (imem_rsp_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (dec_is_ebreak) begin
                    state_next = HALT;
                end else if (dec_is_load || dec_is_store) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                wait_state     = 1'b1;
                exit_cond      = dmem_req_ready;
                dmem_req_valid = !rst;
                dmem_we        = !rst && dec_is_store;
                if (dmem_req_ready) begin
                    state_next = WAIT_D;
                end
            end
            WAIT_D: begin
                wait_state = 1'b1;
                exit_cond  = dmem_rsp_valid;
                if (dmem_rsp_valid) begin
                    state_next = WB;
                end
            end
            WB: begin
                retire = !rst;
                rf_we  = !rst && dec_reg_write;
                if (pc_misaligned) begin
                    state_next = ERR;
                end else begin
                    state_next = FETCH;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = ERR;
            end
        endcase

        // If the exit condition is true on the cycle the limit is reached,
        // the handshake completes normally instead of timing out.
        timed_out = (TIMEOUT != 0) && wait_state && !exit_cond && (wait_cnt == WAIT_MAX);
        if (timed_out) begin
            state_next = ERR;
        end
    end

    assign imem_addr = pc;

endmodule

// File: doc/mc_seq.md
Name: mc_seq

Overview:
Multi-cycle fetch/execute sequencer for the next-generation RV32 core. It replaces the single-cycle "instruction presented every clock" model with valid/ready instruction and data memory handshakes.
- Owns the PC, instruction register, retire counter, halt and bus-error state.
- The existing decode/datapath stays combinational, is driven from the latched instruction, and supplies pc_next and decode flags back to this block.

Parameters:
XLEN, 32, width of PC and data paths
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT, 255, max wait cycles in any handshake state before error; 0 disables the timeout
CNT_W, 64, width of the retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request; imem_addr is valid while high
imem_req_ready  in  1  instruction memory accepts the request
imem_addr  out  XLEN  fetch address; always equals pc
imem_rsp_valid  in  1  instruction data valid
imem_rsp_data  in  32  fetched instruction
inst  out  32  latched instruction driving decode
pc  out  XLEN  current PC
dec_is_load  in  1  decoded load
dec_is_store  in  1  decoded store
dec_is_ebreak  in  1  decoded ebreak (opcode 7'b1110011)
dec_reg_write  in  1  decoded register-file write
pc_next  in  XLEN  next PC computed by the datapath
dmem_req_valid  out  1  data memory request
dmem_req_ready  in  1  data memory accepts the request
dmem_we  out  1  store request; equals dec_is_store while dmem_req_valid is high, else 0
dmem_rsp_valid  in  1  load data valid, or store completion
dmem_rsp_data  in  XLEN  load data
ld_data  out  XLEN  latched load data for register-file writeback
rf_we  out  1  gated register-file write enable
retire  out  1  one-cycle pulse per retired instruction
instret  out  CNT_W  retired-instruction count
halted  out  1  sticky; set by ebreak
bus_err  out  1  sticky; set by timeout or misaligned pc_next

Behaviour:
- Reset values (rst sampled high on a clk edge):
  - pc=RESET_PC, inst=32'h0000_0013, ld_data=0, instret=0.
  - halted=0, bus_err=0, state=FETCH, wait counter=0.
  - All valid, we, rf_we and retire outputs are 0 during the reset cycle.
- rst has priority over every other event, in any state, including mid-handshake. Outstanding responses arriving after reset are ignored.
- States are FETCH, WAIT_I, EXEC, MEM, WAIT_D, WB, HALT, ERR.
- FETCH:
  - imem_req_valid=1.
  - When imem_req_ready=1 -> WAIT_I.
  - The request stays asserted and imem_addr stays stable until accepted.
- WAIT_I:
  - On imem_rsp_valid, inst<=imem_rsp_data -> EXEC.
  - imem_rsp_valid is ignored in every other state. A response needs at least 1 cycle after acceptance.
- EXEC: decode is evaluated on the latched inst. Transitions, in priority order:
  - dec_is_ebreak -> HALT.
  - dec_is_load or dec_is_store -> MEM.
  - otherwise -> WB.
- MEM:
  - dmem_req_valid=1 and dmem_we=dec_is_store.
  - When dmem_req_ready=1 -> WAIT_D.
- WAIT_D:
  - On dmem_rsp_valid -> WB.
  - If the instruction is a load, also ld_data<=dmem_rsp_data.
- WB: a single cycle.
  - rf_we=dec_reg_write and retire=1.
  - instret<=instret+1; wraps modulo 2^CNT_W.
  - pc<=pc_next -> FETCH.
  - If pc_next[1:0]!=0: pc is not updated, retire=1 and rf_we still apply, bus_err<=1 -> ERR.
- HALT:
  - halted=1. No requests, rf_we=0, retire=0.
  - pc and instret are frozen. Only rst exits.
  - ebreak does not retire.
- ERR:
  - bus_err=1. No requests, pc frozen. Only rst exits.
- Timeout:
  - The wait counter clears on entry to FETCH, WAIT_I, MEM and WAIT_D.
  - It increments each cycle the state's exit condition is false.
  - When the counter == TIMEOUT and the exit condition is still false -> ERR, bus_err<=1.
  - An exit condition true on that same cycle wins over the timeout.
- Latency with zero-wait memory (ready=1, response 1 cycle after acceptance):
  - ALU or branch instruction: 4 cycles (FETCH, WAIT_I, EXEC, WB).
  - Load or store: 6 cycles.
- rf_we is high only in WB. No register-file write occurs in any other state.

Test Plan:
- Reset, then zero-wait imem returning addi x1,x0,5 (32'h0050_0093) with pc_next=pc+4 -> imem_addr=32'h8000_0000; rf_we=1 and retire=1 on cycle 4; pc=32'h8000_0004; instret=1.
- imem_req_ready held low 3 cycles -> imem_req_valid stays 1 and imem_addr stable for 4 cycles; state advances only on the ready cycle.
- Load with dmem_rsp_data=32'hDEAD_BEEF after 2 wait cycles -> ld_data=32'hDEAD_BEEF at WB; dmem_we=0; retire on cycle 8.
- Store -> dmem_req_valid=1 with dmem_we=1 for one accepted cycle; retire=1; rf_we=0 when dec_reg_write=0.
- ebreak (32'h0010_0073) -> halted=1; no further imem_req_valid; instret unchanged. Assert rst -> pc=32'h8000_0000, halted=0.
- TIMEOUT=4 and imem_rsp_valid never asserted -> bus_err=1 exactly 5 cycles after entering WAIT_I.
- pc_next=32'h8000_0006 -> bus_err=1 and pc unchanged.
- rst asserted mid-WAIT_D -> FETCH next; a late dmem_rsp_valid is ignored.
